// File: rtl/gcd_arbiter_if.sv
interface gcd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_gcd;
  logic              resp_err;
  logic              eng_start;
  logic [W-1:0]      eng_x0;
  logic [W-1:0]      eng_y0;
  logic              eng_rst;
  logic              eng_done;
  logic [W-1:0]      eng_gcd;

  modport slave (
    input  req, req_x, req_y, eng_done, eng_gcd,
    output gnt, busy, resp_valid, resp_id, resp_gcd, resp_err,
           eng_start, eng_x0, eng_y0, eng_rst
  );

  modport master (
    output req, req_x, req_y, eng_done, eng_gcd,
    input  gnt, busy, resp_valid, resp_id, resp_gcd, resp_err,
           eng_start, eng_x0, eng_y0, eng_rst
  );
endinterface

// File: rtl/gcd_arbiter.sv
module gcd_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  gcd_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [W-1:0]    resp_gcd_q, resp_gcd_d;
  logic            resp_err_q, resp_err_d;
  logic            eng_start_q, eng_start_d;
  logic [W-1:0]    eng_x0_q, eng_x0_d;
  logic [W-1:0]    eng_y0_q, eng_y0_d;
  logic            abort_q, abort_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  cand;
  logic [W-1:0]    sel_x, sel_y;

  // Walk forward from rr_ptr+1 with an explicit modulo-NREQ wrap so non-power-of-2 NREQ works.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = rr_ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    sel_x = '0;
    sel_y = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        sel_x = bus.req_x[i*W +: W];
        sel_y = bus.req_y[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_gcd_d   = resp_gcd_q;
    resp_err_d   = resp_err_q;
    eng_start_d  = 1'b0;
    eng_x0_d     = eng_x0_q;
    eng_y0_d     = eng_y0_q;
    abort_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          rr_ptr_d   = win;
          eng_x0_d   = sel_x;
          eng_y0_d   = sel_y;
          gnt_d[win] = 1'b1;
          if (sel_x == '0 || sel_y == '0) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_id_d    = win;
            resp_gcd_d   = sel_x | sel_y;
            resp_err_d   = 1'b0;
          end else begin
            state_d     = START;
            eng_start_d = 1'b1;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.eng_done) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = rr_ptr_q;
          resp_gcd_d   = bus.eng_gcd;
          resp_err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = rr_ptr_q;
          resp_gcd_d   = '0;
          resp_err_d   = 1'b1;
          abort_d      = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDW'(NREQ - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_gcd_q   <= '0;
      resp_err_q   <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_x0_q     <= '0;
      eng_y0_q     <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_gcd_q   <= resp_gcd_d;
      resp_err_q   <= resp_err_d;
      eng_start_q  <= eng_start_d;
      eng_x0_q     <= eng_x0_d;
      eng_y0_q     <= eng_y0_d;
      abort_q      <= abort_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_gcd   = resp_gcd_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_x0     = eng_x0_q;
  assign bus.eng_y0     = eng_y0_q;
  // Engine is held in reset with the arbiter and kicked for the RESP cycle after a timeout.
  assign bus.eng_rst    = ~rst | abort_q;
endmodule

// File: tb/tb_gcd_arbiter.sv
module tb_gcd_arbiter;
  logic clk = 1'b0;
  logic rst;
  bit   stub_hang = 1'b0;

  gcd_arbiter_if #(.NREQ(4), .W(4)) bus ();

  gcd_arbiter #(.NREQ(4), .W(4), .TIMEOUT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  // Subtractive GCD engine: done is combinational once the operands meet.
  bit [3:0] ex = 4'd0;
  bit [3:0] ey = 4'd0;
  bit       e_run = 1'b0;

  always @(posedge clk) begin
    if (bus.eng_rst) begin
      e_run <= 1'b0;
    end else if (bus.eng_start && !stub_hang) begin
      ex    <= bus.eng_x0;
      ey    <= bus.eng_y0;
      e_run <= 1'b1;
    end else if (e_run) begin
      if (ex == ey)     e_run <= 1'b0;
      else if (ex > ey) ex <= ex - ey;
      else              ey <= ey - ex;
    end
  end

  assign bus.eng_done = e_run && (ex == ey);
  assign bus.eng_gcd  = ex;

  typedef struct {
    int id;
    int gcd;
    int err;
  } resp_t;

  resp_t exp_q[$];
  int    gnt_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int rstp_cnt = 0;
  int resp_cnt = 0;
  int last_gnt_cyc = 0;
  int last_resp_cyc = 0;
  int last_start_cyc = 0;
  int resp_rst_flag = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.eng_start) begin
        start_cnt++;
        last_start_cyc = cyc;
      end
      if (bus.eng_rst) rstp_cnt++;
      if (|bus.gnt) begin
        last_gnt_cyc = cyc;
        chk("gnt_onehot", $countones(bus.gnt), 1);
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", int'(bus.gnt), 0);
        end else begin
          int e;
          e = gnt_q.pop_front();
          chk("gnt_id", int'(bus.gnt), 1 << e);
        end
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        resp_rst_flag = int'(bus.eng_rst);
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          resp_t r;
          r = exp_q.pop_front();
          chk("resp_id", int'(bus.resp_id), r.id);
          chk("resp_gcd", int'(bus.resp_gcd), r.gcd);
          chk("resp_err", int'(bus.resp_err), r.err);
        end
      end
    end
  end

  task automatic expect_txn(input int id, input int gcd, input int err);
    resp_t r;
    r.id  = id;
    r.gcd = gcd;
    r.err = err;
    gnt_q.push_back(id);
    exp_q.push_back(r);
  endtask

  task automatic set_req(input int id, input int x, input int y);
    bus.req_x[id*4 +: 4] = 4'(x);
    bus.req_y[id*4 +: 4] = 4'(y);
    bus.req[id] = 1'b1;
  endtask

  // Requesters drop req on seeing their grant; returns once everything has drained.
  task automatic settle(input string name, input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.gnt;
      if (exp_q.size() == 0 && !bus.busy && bus.req == '0) break;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, budget);
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    int v0;
    int n;
    rst       = 1'b0;
    bus.req   = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    repeat (3) @(negedge clk);

    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_resp_id", int'(bus.resp_id), 0);
    chk("rst_resp_gcd", int'(bus.resp_gcd), 0);
    chk("rst_resp_err", int'(bus.resp_err), 0);
    chk("rst_eng_start", int'(bus.eng_start), 0);
    chk("rst_eng_x0", int'(bus.eng_x0), 0);
    chk("rst_eng_y0", int'(bus.eng_y0), 0);
    chk("rst_eng_rst", int'(bus.eng_rst), 1);
    rst = 1'b1;
    @(negedge clk);

    // Contention: rr_ptr=3 after reset, so order is 0,1,2,3.
    expect_txn(0, 3, 0);
    expect_txn(1, 2, 0);
    expect_txn(2, 5, 0);
    expect_txn(3, 4, 0);
    set_req(0, 9, 6);
    set_req(1, 10, 4);
    set_req(2, 15, 5);
    set_req(3, 8, 12);
    settle("contention", 200);

    // Single request: 0 wins again after 3.
    s0 = start_cnt;
    expect_txn(0, 4, 0);
    set_req(0, 12, 8);
    settle("single", 50);
    chk("single_starts", start_cnt - s0, 1);
    chk("single_busy_after", int'(bus.busy), 0);

    // Equal operands: engine reports done in the first WAIT cycle.
    expect_txn(2, 7, 0);
    set_req(2, 7, 7);
    settle("equal", 50);
    chk("equal_latency", last_resp_cyc - last_gnt_cyc, 2);

    // Zero bypass.
    s0 = start_cnt;
    expect_txn(1, 9, 0);
    set_req(1, 0, 9);
    settle("bypass", 50);
    chk("bypass_same_cycle", last_resp_cyc - last_gnt_cyc, 0);
    chk("bypass_no_start", start_cnt - s0, 0);
    expect_txn(3, 0, 0);
    set_req(3, 0, 0);
    settle("bypass_zero", 50);
    chk("bypass_zero_no_start", start_cnt - s0, 0);

    // Timeout with a hung engine.
    stub_hang = 1'b1;
    r0 = rstp_cnt;
    expect_txn(0, 0, 1);
    set_req(0, 6, 4);
    settle("timeout", 100);
    chk("timeout_wait_cycles", last_resp_cyc - last_start_cyc, 33);
    chk("timeout_eng_rst_pulses", rstp_cnt - r0, 1);
    chk("timeout_eng_rst_at_resp", resp_rst_flag, 1);
    stub_hang = 1'b0;
    expect_txn(1, 2, 0);
    set_req(1, 6, 4);
    settle("after_timeout", 50);

    // Async reset mid-WAIT: transaction dropped, rr_ptr back to NREQ-1.
    stub_hang = 1'b1;
    gnt_q.push_back(2);
    set_req(2, 6, 4);
    n = 0;
    while (1) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.gnt;
      if (bus.eng_start) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL reset_wait_start: no eng_start after 20 cycles, required 1");
        break;
      end
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", int'(bus.busy), 0);
    chk("async_gnt", int'(bus.gnt), 0);
    chk("async_resp_valid", int'(bus.resp_valid), 0);
    chk("async_resp_gcd", int'(bus.resp_gcd), 0);
    chk("async_resp_err", int'(bus.resp_err), 0);
    chk("async_eng_start", int'(bus.eng_start), 0);
    chk("async_eng_x0", int'(bus.eng_x0), 0);
    chk("async_eng_rst", int'(bus.eng_rst), 1);
    v0 = resp_cnt;
    repeat (3) @(negedge clk);
    stub_hang = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    expect_txn(1, 2, 0);
    expect_txn(3, 3, 0);
    set_req(1, 6, 4);
    set_req(3, 9, 3);
    settle("post_reset", 100);
    chk("post_reset_resp_count", resp_cnt - v0, 2);

    chk("resp_queue_empty", exp_q.size(), 0);
    chk("gnt_queue_empty", gnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
